// File: rtl/lcd1602_reader.sv
// lcd1602_reader
// Read-side companion to the LCD1602 write driver. Runs HD44780 read cycles
// (RW=1): busy-flag/address reads (RS=0), DDRAM/CGRAM data reads (RS=1), and a
// polled wait-until-not-busy loop. The top level hands RS/RW/E to this block
// whenever bus_own is high.
//
// Ports:
//   CLK                         system clock (50 MHz)
//   clear                       synchronous active-high reset
//   req_status/req_data/req_poll  transaction requests, sampled only when idle
//                               (priority poll > status > data)
//   busy                        transaction in progress, requests dropped
//   valid                       one-cycle result strobe
//   rd_data                     byte captured by the last read
//   bf/ac                       busy flag / address counter of last status read
//   timeout                     poll ended with BF still set
//   bus_own                     this block drives RS/RW/E
//   LCD_RS/LCD_RW/LCD_E         LCD control lines
//   LCD_DATA                    LCD data bus, never driven here (sampled only)
//
// Build option: define LCD_READ_SYNC_EN to pass LCD_DATA through a 2-flop
// synchronizer; E_HI then lasts 2 extra cycles so the captured byte reflects
// the bus at T_PW.

module lcd1602_reader #(
  parameter int T_AS     = 2,
  parameter int T_PW     = 12,
  parameter int T_H      = 2,
  parameter int T_GAP    = 25,
  parameter int POLL_MAX = 255
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       req_status,
  input  logic       req_data,
  input  logic       req_poll,
  output logic       busy,
  output logic       valid,
  output logic [7:0] rd_data,
  output logic       bf,
  output logic [6:0] ac,
  output logic       timeout,
  output logic       bus_own,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  inout  wire  [7:0] LCD_DATA
);

  typedef enum logic [2:0] {IDLE, SETUP, E_HI, HOLD, GAP, DONE} state_t;

`ifdef LCD_READ_SYNC_EN
  localparam int EXT = 2;
  logic [7:0] sync1, sync2;
  always_ff @(posedge CLK) begin
    if (clear) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= LCD_DATA;
      sync2 <= sync1;
    end
  end
  wire [7:0] smp = sync2;
`else
  localparam int EXT = 0;
  wire [7:0] smp = LCD_DATA;
`endif

  // terminal counts (phase counter restarts at 0 on every state change)
  localparam logic [15:0] AS_L  = 16'(T_AS - 1);
  localparam logic [15:0] PW_L  = 16'(T_PW + EXT - 1);
  localparam logic [15:0] H_L   = 16'(T_H - 1);
  localparam logic [15:0] GAP_L = 16'(T_GAP - 1);
  localparam logic [7:0]  PMAX  = 8'(POLL_MAX);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [7:0]  rd_cnt;
  logic        rs_q, poll_mode;

  assign LCD_DATA = 8'bz;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (req_poll || req_status || req_data) state_n = SETUP;
      SETUP: if (cnt == AS_L) state_n = E_HI;
      E_HI:  if (cnt == PW_L) state_n = HOLD;
      // bf already holds this read's flag: it was captured on the last E_HI cycle
      HOLD:  if (cnt == H_L)
               state_n = (poll_mode && bf && (rd_cnt < PMAX)) ? GAP : DONE;
      GAP:   if (cnt == GAP_L) state_n = SETUP;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // control lines decode straight from state so clear drops them on the next edge
  always_comb begin
    bus_own = 1'b0;
    LCD_E   = 1'b0;
    valid   = 1'b0;
    case (state)
      SETUP, HOLD, GAP: bus_own = 1'b1;
      E_HI: begin
        bus_own = 1'b1;
        LCD_E   = 1'b1;
      end
      DONE:    valid = 1'b1;
      default: ;
    endcase
    busy   = bus_own;
    LCD_RW = bus_own;
    LCD_RS = bus_own & rs_q;
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      state     <= IDLE;
      cnt       <= '0;
      rs_q      <= 1'b0;
      poll_mode <= 1'b0;
      rd_cnt    <= '0;
      rd_data   <= '0;
      bf        <= 1'b0;
      ac        <= '0;
      timeout   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= (state_n != state || state == IDLE) ? 16'd0 : cnt + 16'd1;
      if (state == IDLE && state_n == SETUP) begin
        poll_mode <= req_poll;
        rs_q      <= ~req_poll & ~req_status;
        rd_cnt    <= '0;
      end
      if (state == E_HI && state_n == HOLD) begin
        rd_data <= smp;
        rd_cnt  <= rd_cnt + 8'd1;
        if (!rs_q) begin
          bf <= smp[7];
          ac <= smp[6:0];
        end
      end
      if (state == HOLD && state_n == DONE)
        timeout <= poll_mode & bf;
    end
  end

endmodule

// File: tb/tb_lcd1602_reader.sv
module tb_lcd1602_reader;

`ifdef LCD_READ_SYNC_EN
  localparam int EXT = 2;
`else
  localparam int EXT = 0;
`endif
  localparam int LAT  = 17 + EXT;
  localparam int STEP = 41 + EXT;

  logic CLK = 1'b0;
  always #10 CLK = ~CLK;

  logic       clear = 1'b0, req_status = 1'b0, req_data = 1'b0, req_poll = 1'b0;
  logic       busy, valid, bf, timeout, bus_own, LCD_RS, LCD_RW, LCD_E;
  logic [7:0] rd_data;
  logic [6:0] ac;
  logic [7:0] lcd_val = 8'h00;
  wire  [7:0] lcd_bus;
  assign lcd_bus = lcd_val;

  // second instance: POLL_MAX=3 against a display whose BF never clears
  logic       req_poll2 = 1'b0;
  logic       busy2, valid2, bf2, timeout2, bus_own2, rs2, rw2, e2;
  logic [7:0] rd_data2;
  logic [6:0] ac2;
  wire  [7:0] lcd_bus2;
  assign lcd_bus2 = 8'h85;

  lcd1602_reader u_dut (
    .CLK(CLK), .clear(clear), .req_status(req_status), .req_data(req_data),
    .req_poll(req_poll), .busy(busy), .valid(valid), .rd_data(rd_data), .bf(bf),
    .ac(ac), .timeout(timeout), .bus_own(bus_own), .LCD_RS(LCD_RS),
    .LCD_RW(LCD_RW), .LCD_E(LCD_E), .LCD_DATA(lcd_bus)
  );

  lcd1602_reader #(.POLL_MAX(3)) u_dut2 (
    .CLK(CLK), .clear(clear), .req_status(1'b0), .req_data(1'b0),
    .req_poll(req_poll2), .busy(busy2), .valid(valid2), .rd_data(rd_data2), .bf(bf2),
    .ac(ac2), .timeout(timeout2), .bus_own(bus_own2), .LCD_RS(rs2),
    .LCD_RW(rw2), .LCD_E(e2), .LCD_DATA(lcd_bus2)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // LCD model: returns busy_byte for the first busy_reads reads, then ready_byte
  int         busy_reads;
  logic [7:0] busy_byte, ready_byte;
  task automatic model(input int n, input logic [7:0] b, input logic [7:0] r);
    busy_reads = n; busy_byte = b; ready_byte = r;
    lcd_val = (n > 0) ? b : r;
  endtask

  int   rises[$];
  int   v_cyc, nvalid, busy_bad, fall_c, rs_r, rw_r, vb, vo;
  logic eprev;

  // issue one request; cycle numbering: request edge = 0, first cycle after it = 1
  task automatic go(input logic p, input logic s, input logic d);
    @(negedge CLK); req_poll = p; req_status = s; req_data = d;
    @(negedge CLK); req_poll = 0; req_status = 0; req_data = 0;
    rises.delete();
    v_cyc = -1; nvalid = 0; busy_bad = 0; fall_c = -1; rs_r = -1; rw_r = -1;
    vb = -1; vo = -1; eprev = 1'b0;
    for (int rel = 1; rel < 4000; rel++) begin
      if (LCD_E && !eprev) begin
        rises.push_back(rel); rs_r = int'(LCD_RS); rw_r = int'(LCD_RW);
      end
      if (!LCD_E && eprev) begin
        if (fall_c < 0) fall_c = rel;
        if (busy_reads > 0) busy_reads--;
        lcd_val = (busy_reads > 0) ? busy_byte : ready_byte;
      end
      if (valid) begin
        nvalid++;
        if (v_cyc < 0) begin v_cyc = rel; vb = int'(busy); vo = int'(bus_own); end
      end else if (v_cyc < 0 && !busy) busy_bad++;
      eprev = LCD_E;
      if (v_cyc > 0 && rel >= v_cyc + 5) break;
      @(negedge CLK);
    end
    chk("valid_seen", int'(v_cyc > 0), 1);
  endtask

  int bad, np, v2;
  logic ep;

  initial begin
    // reset and quiet period
    model(0, 8'h00, 8'h5A);
    clear = 1; repeat (2) @(negedge CLK); clear = 0;
    @(negedge CLK);
    chk("rst_outs", int'({busy, valid, rd_data, bf, ac, timeout, bus_own, LCD_RS, LCD_RW, LCD_E}), 0);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if ({busy, valid, rd_data, bf, ac, timeout, bus_own, LCD_RS, LCD_RW, LCD_E} != '0) bad++;
      @(negedge CLK);
    end
    chk("rst_quiet_100", bad, 0);

    // status read
    model(0, 8'h00, 8'h25);
    go(0, 1, 0);
    chk("st_e_rise", rises.size() > 0 ? rises[0] : -1, 3);
    chk("st_e_fall", fall_c, 15 + EXT);
    chk("st_rs", rs_r, 0);
    chk("st_rw", rw_r, 1);
    chk("st_valid_cyc", v_cyc, LAT);
    chk("st_busy_gap", busy_bad, 0);
    chk("st_busy_in_valid", vb, 0);
    chk("st_own_in_valid", vo, 0);
    chk("st_rd_data", int'(rd_data), 'h25);
    chk("st_bf", int'(bf), 0);
    chk("st_ac", int'(ac), 'h25);
    chk("st_timeout", int'(timeout), 0);

    // data read: bf/ac untouched
    model(0, 8'h00, 8'h41);
    go(0, 0, 1);
    chk("dt_rs", rs_r, 1);
    chk("dt_valid_cyc", v_cyc, LAT);
    chk("dt_rd_data", int'(rd_data), 'h41);
    chk("dt_bf", int'(bf), 0);
    chk("dt_ac", int'(ac), 'h25);

    // poll: busy for 3 reads then ready
    model(3, 8'hA0, 8'h20);
    go(1, 0, 0);
    chk("pl_pulses", rises.size(), 4);
    chk("pl_step", rises.size() > 1 ? rises[1] - rises[0] : -1, STEP);
    chk("pl_last_rise", rises.size() > 3 ? rises[3] : -1, 3 + 3 * STEP);
    chk("pl_valid_cyc", v_cyc, LAT + 3 * STEP);
    chk("pl_nvalid", nvalid, 1);
    chk("pl_bf", int'(bf), 0);
    chk("pl_ac", int'(ac), 'h20);
    chk("pl_timeout", int'(timeout), 0);

    // poll and data together: poll wins, RS=0
    model(0, 8'h00, 8'h12);
    go(1, 0, 1);
    chk("pd_rs", rs_r, 0);
    chk("pd_pulses", rises.size(), 1);
    chk("pd_ac", int'(ac), 'h12);

    // clear during E high
    model(0, 8'h00, 8'h33);
    @(negedge CLK); req_status = 1;
    @(negedge CLK); req_status = 0;
    repeat (7) @(negedge CLK);
    chk("cl_e_before", int'(LCD_E), 1);
    clear = 1; @(negedge CLK); clear = 0;
    chk("cl_e", int'(LCD_E), 0);
    chk("cl_own", int'(bus_own), 0);
    chk("cl_busy", int'(busy), 0);
    chk("cl_rd_ac", int'({rd_data, ac}), 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid || LCD_E) bad++;
      @(negedge CLK);
    end
    chk("cl_no_valid", bad, 0);
    model(0, 8'h00, 8'h25);
    go(0, 1, 0);
    chk("cl_after_valid_cyc", v_cyc, LAT);
    chk("cl_after_rd", int'(rd_data), 'h25);

    // POLL_MAX=3 with BF stuck high
    @(negedge CLK); req_poll2 = 1;
    @(negedge CLK); req_poll2 = 0;
    np = 0; v2 = -1; ep = 1'b0;
    for (int r = 1; r < 2000 && v2 < 0; r++) begin
      if (e2 && !ep) np++;
      if (valid2) v2 = r;
      ep = e2;
      if (v2 < 0) @(negedge CLK);
    end
    chk("pm_pulses", np, 3);
    chk("pm_valid_cyc", v2, LAT + 2 * STEP);
    chk("pm_timeout", int'(timeout2), 1);
    chk("pm_bf", int'(bf2), 1);
    chk("pm_ac", int'(ac2), 'h05);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
